// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path.
// Holds the sequencer state encoding and the wait-timer width.
package cpu_pkg;

   localparam int STATE_W = 3;

   // Wide enough for the largest MEM dwell preload (15 - 1)
   localparam int WAIT_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter that measures how long a memory access dwells.
// Preloaded on 'load', counts down on 'dec', and flags zero.
// Kept separate so later memory-latency models can reuse it.
module mem_wait_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [WIDTH-1:0] load_value,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   // Preload takes priority over decrement; the count stops at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/cycle_sequencer.sv
// Multi-cycle control sequencer for the RISC-V datapath.
// Steps each instruction through FETCH, DECODE, EXEC, optional MEM
// and WB, and drives the datapath strobes from registered state.
// Optional feature: define INSTRET_CNT_EN to build the 32-bit
// retired-instruction counter; otherwise instret reads 0.
module cycle_sequencer #(
   parameter int MEM_WAIT_CYCLES = 1,
   parameter int STATE_W         = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               step,
   input  logic               halt_req,
   input  logic               load_enb,
   input  logic               store_enb,
   input  logic               wenb,
   input  logic               ebreak,
   output logic               ir_load,
   output logic               mem_enb,
   output logic               rf_wenb,
   output logic               pc_write,
   output logic               busy,
   output logic               halted,
   output logic [STATE_W-1:0] state,
   output logic [31:0]        instret
);

   import cpu_pkg::*;

   localparam logic [WAIT_W-1:0] WAIT_PRELOAD = WAIT_W'(MEM_WAIT_CYCLES - 1);

   state_t cur_state;
   state_t next_state;
   logic   single_step;
   logic   next_single_step;
   logic   timer_load;
   logic   timer_dec;
   logic   timer_zero;

   // The MEM dwell counter lives in its own reusable timer
   mem_wait_timer #(
      .WIDTH (WAIT_W)
   ) u_mem_wait_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .dec        (timer_dec),
      .load_value (WAIT_PRELOAD),
      .zero       (timer_zero)
   );

   // State register plus the single-step flag that rides along with it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state   <= S_IDLE;
         single_step <= 1'b0;
      end else begin
         cur_state   <= next_state;
         single_step <= next_single_step;
      end
   end

   // Next-state logic; halt_req, run and ebreak only matter in IDLE and WB
   always_comb begin
      next_state       = cur_state;
      next_single_step = single_step;
      timer_load       = 1'b0;
      timer_dec        = 1'b0;
      unique case (cur_state)
         S_IDLE: begin
            if (run) begin
               next_state       = S_FETCH;
               next_single_step = 1'b0;
            end else if (step) begin
               next_state       = S_FETCH;
               next_single_step = 1'b1;
            end
         end
         S_FETCH: begin
            next_state = S_DECODE;
         end
         S_DECODE: begin
            next_state = S_EXEC;
         end
         S_EXEC: begin
            if (load_enb || store_enb) begin
               timer_load = 1'b1;
               next_state = S_MEM;
            end else begin
               next_state = S_WB;
            end
         end
         S_MEM: begin
            if (timer_zero) begin
               next_state = S_WB;
            end else begin
               timer_dec = 1'b1;
            end
         end
         S_WB: begin
            if (ebreak) begin
               next_state = S_HALT;
            end else if (halt_req || single_step || !run) begin
               next_state       = S_IDLE;
               next_single_step = 1'b0;
            end else begin
               next_state = S_FETCH;
            end
         end
         S_HALT: begin
            next_state = S_HALT;
         end
         default: begin
            next_state       = S_IDLE;
            next_single_step = 1'b0;
         end
      endcase
   end

   // Strobes decoded from state; rf_wenb also masks stores out of the write-back
   always_comb begin
      ir_load  = (cur_state == S_FETCH);
      mem_enb  = (cur_state == S_MEM);
      pc_write = (cur_state == S_WB);
      rf_wenb  = (cur_state == S_WB) && wenb && !store_enb;
      halted   = (cur_state == S_HALT);
      busy     = (cur_state != S_IDLE) && (cur_state != S_HALT);
   end

   assign state = STATE_W'(cur_state);

`ifdef INSTRET_CNT_EN
   logic [31:0] instret_count;

   // Every WB cycle retires one instruction; the count wraps naturally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_count <= '0;
      end else if (cur_state == S_WB) begin
         instret_count <= instret_count + 32'd1;
      end
   end

   assign instret = instret_count;
`else
   assign instret = '0;
`endif

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed testbench for cycle_sequencer with MEM_WAIT_CYCLES=3.
// Each step drives the inputs for one cycle and queues the outputs
// expected in that cycle; the queue is drained and compared before
// the next clock edge.
module tb_cycle_sequencer;

   typedef struct {
      logic [2:0]  st;
      logic        irl;
      logic        mem;
      logic        rfw;
      logic        pcw;
      logic        bsy;
      logic        hlt;
      logic [31:0] ir;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        run;
   logic        step;
   logic        halt_req;
   logic        load_enb;
   logic        store_enb;
   logic        wenb;
   logic        ebreak;
   logic        ir_load;
   logic        mem_enb;
   logic        rf_wenb;
   logic        pc_write;
   logic        busy;
   logic        halted;
   logic [2:0]  state;
   logic [31:0] instret;

   int   checks;
   int   failures;
   exp_t sb[$];

   cycle_sequencer #(
      .MEM_WAIT_CYCLES (3),
      .STATE_W         (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .run       (run),
      .step      (step),
      .halt_req  (halt_req),
      .load_enb  (load_enb),
      .store_enb (store_enb),
      .wenb      (wenb),
      .ebreak    (ebreak),
      .ir_load   (ir_load),
      .mem_enb   (mem_enb),
      .rf_wenb   (rf_wenb),
      .pc_write  (pc_write),
      .busy      (busy),
      .halted    (halted),
      .state     (state),
      .instret   (instret)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected outputs for a given state, derived from the state encoding
   function automatic exp_t mk(input int st, input logic rfw, input int n);
      exp_t e;
      e.st  = 3'(st);
      e.irl = (st == 1);
      e.mem = (st == 4);
      e.pcw = (st == 5);
      e.bsy = (st >= 1) && (st <= 5);
      e.hlt = (st == 6);
      e.rfw = rfw;
`ifdef INSTRET_CNT_EN
      e.ir  = 32'(n);
`else
      e.ir  = 32'd0 + 32'(n - n);
`endif
      return e;
   endfunction

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of inputs and queue what the DUT should show
   task automatic applyStimulus(input logic r, input logic s, input logic h,
                                input logic ld, input logic st, input logic we,
                                input logic eb, input exp_t e);
      run       = r;
      step      = s;
      halt_req  = h;
      load_enb  = ld;
      store_enb = st;
      wenb      = we;
      ebreak    = eb;
      sb.push_back(e);
   endtask

   // Pop the oldest expectation and compare every output against it
   task automatic checkOutput();
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
         failures++;
         $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         compare("state",    32'(state),    32'(e.st));
         compare("ir_load",  32'(ir_load),  32'(e.irl));
         compare("mem_enb",  32'(mem_enb),  32'(e.mem));
         compare("rf_wenb",  32'(rf_wenb),  32'(e.rfw));
         compare("pc_write", 32'(pc_write), 32'(e.pcw));
         compare("busy",     32'(busy),     32'(e.bsy));
         compare("halted",   32'(halted),   32'(e.hlt));
         compare("instret",  instret,       e.ir);
      end
   endtask

   // One full cycle: drive, settle, check, then advance past the next edge
   task automatic cyc(input logic r, input logic s, input logic h,
                      input logic ld, input logic st, input logic we,
                      input logic eb, input exp_t e);
      applyStimulus(r, s, h, ld, st, we, eb, e);
      #1;
      checkOutput();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      run       = 1'b0;
      step      = 1'b0;
      halt_req  = 1'b0;
      load_enb  = 1'b0;
      store_enb = 1'b0;
      wenb      = 1'b0;
      ebreak    = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] reset state");
      cyc(0,0,0,0,0,0,0, mk(0,0,0));
      reset = 1'b0;

      $display("[TB] ADD under run");
      cyc(1,0,0,0,0,1,0, mk(0,0,0));
      cyc(1,0,0,0,0,1,0, mk(1,0,0));
      cyc(1,0,0,0,0,1,0, mk(2,0,0));
      cyc(1,0,0,0,0,1,0, mk(3,0,0));
      cyc(1,0,0,0,0,1,0, mk(5,1,0));

      $display("[TB] load with three MEM cycles");
      cyc(1,0,0,1,0,1,0, mk(1,0,1));
      cyc(1,0,0,1,0,1,0, mk(2,0,1));
      cyc(1,0,0,1,0,1,0, mk(3,0,1));
      for (int i = 0; i < 3; i++) cyc(1,0,0,1,0,1,0, mk(4,0,1));
      cyc(1,0,0,1,0,1,0, mk(5,1,1));

      $display("[TB] store with halt_req raised in EXEC");
      cyc(1,0,0,0,1,1,0, mk(1,0,2));
      cyc(1,0,0,0,1,1,0, mk(2,0,2));
      cyc(1,0,1,0,1,1,0, mk(3,0,2));
      for (int i = 0; i < 3; i++) cyc(1,0,1,0,1,1,0, mk(4,0,2));
      cyc(1,0,1,0,1,1,0, mk(5,0,2));
      cyc(0,0,0,0,0,0,0, mk(0,0,3));
      cyc(0,0,0,0,0,0,0, mk(0,0,3));

      $display("[TB] single-step pulses");
      cyc(0,1,0,0,0,1,0, mk(0,0,3));
      cyc(0,0,0,0,0,1,0, mk(1,0,3));
      cyc(0,0,0,0,0,1,0, mk(2,0,3));
      cyc(0,0,0,0,0,1,0, mk(3,0,3));
      cyc(0,0,0,0,0,1,0, mk(5,1,3));
      cyc(0,0,0,0,0,0,0, mk(0,0,4));
      cyc(0,0,0,0,0,0,0, mk(0,0,4));
      cyc(0,1,0,0,0,1,0, mk(0,0,4));
      cyc(0,0,0,0,0,1,0, mk(1,0,4));
      cyc(0,0,0,0,0,1,0, mk(2,0,4));
      cyc(0,0,0,0,0,1,0, mk(3,0,4));
      cyc(0,0,0,0,0,1,0, mk(5,1,4));
      cyc(0,0,0,0,0,0,0, mk(0,0,5));

      $display("[TB] ebreak into HALT");
      cyc(1,0,0,0,0,1,0, mk(0,0,5));
      cyc(1,0,0,0,0,1,0, mk(1,0,5));
      cyc(1,0,0,0,0,1,0, mk(2,0,5));
      cyc(1,0,0,0,0,1,0, mk(3,0,5));
      cyc(1,0,0,0,0,1,1, mk(5,1,5));
      for (int i = 0; i < 20; i++) cyc(1, 1'(i % 2), 0,0,0,1,0, mk(6,0,6));

      $display("[TB] reset out of HALT");
      reset = 1'b1;
      applyStimulus(1,0,0,0,0,1,0, mk(0,0,0));
      #1;
      checkOutput();
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] reset during MEM");
      cyc(1,0,0,0,0,1,0, mk(0,0,0));
      cyc(1,0,0,0,0,1,0, mk(1,0,0));
      cyc(1,0,0,0,0,1,0, mk(2,0,0));
      cyc(1,0,0,0,0,1,0, mk(3,0,0));
      cyc(1,0,0,0,0,1,0, mk(5,1,0));
      cyc(1,0,0,1,0,1,0, mk(1,0,1));
      cyc(1,0,0,1,0,1,0, mk(2,0,1));
      cyc(1,0,0,1,0,1,0, mk(3,0,1));
      cyc(1,0,0,1,0,1,0, mk(4,0,1));
      applyStimulus(1,0,0,1,0,1,0, mk(4,0,1));
      #1;
      checkOutput();
      #1;
      reset = 1'b1;
      applyStimulus(1,0,0,1,0,1,0, mk(0,0,0));
      #1;
      checkOutput();
      @(posedge clk);
      #1;
      reset = 1'b0;
      cyc(0,0,0,0,0,0,0, mk(0,0,0));
      cyc(0,0,0,0,0,0,0, mk(0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
